// File: rtl/orgate_stim_pkg.sv
// Shared types and constants for the OR-gate stimulus sequencer.
package orgate_stim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] MODE_BIN  = 2'b00;
   localparam logic [1:0] MODE_GRAY = 2'b01;
   localparam logic [1:0] MODE_WALK = 2'b10;

   localparam logic [3:0] LAST_16   = 4'd15;
   localparam logic [3:0] LAST_WALK = 4'd3;

   // Final pattern index for a mode; reserved mode 11 runs the full 16 like binary.
   function automatic logic [3:0] last_index(input logic [1:0] mode);
      logic [3:0] last;
      case (mode)
         MODE_WALK: last = LAST_WALK;
         default:   last = LAST_16;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/orgate_stim_gen_pattern_map.sv
// Combinational mapping from (mode, index) to the 4-bit stimulus pattern.
module stim_pattern_map
   import orgate_stim_pkg::*;
(
   input  logic [1:0] mode_i,
   input  logic [3:0] index_i,
   output logic [3:0] pattern_o
);

   // Pattern selection; walking-one only ever sees indices 0..3.
   always_comb begin
      pattern_o = 4'd0;
      case (mode_i)
         MODE_BIN:  pattern_o = index_i;
         MODE_GRAY: pattern_o = index_i ^ (index_i >> 1);
         MODE_WALK: pattern_o = 4'b0001 << index_i[1:0];
         default:   pattern_o = index_i;
      endcase
   end

endmodule

// File: rtl/orgate_stim_gen.sv
// Stimulus sequencer driving the a..d inputs of the 4-input OR-gate stage.
// All outputs are registered from the next-state values, so a start sampled
// at edge N shows pattern 0 with valid high in the very next cycle.
module orgate_stim_gen
   import orgate_stim_pkg::*;
#(
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic [HOLD_W-1:0] hold,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              d,
   output logic              valid,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [3:0]        index_q, index_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [1:0]        mode_q, mode_d;
   logic [3:0]        pat_q;
   logic              valid_q, busy_q, done_q;
   logic [3:0]        pat_s;

   // Next-state logic: sequencing, hold countdown and parameter latching.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
               index_d = 4'd0;
               cnt_d   = hold;
               hold_d  = hold;
               mode_d  = mode;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q == {HOLD_W{1'b0}}) begin
               // Compare before incrementing so the index can never wrap.
               if (index_q == last_index(mode_q)) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + 4'd1;
                  cnt_d   = hold_q;
               end
            end else begin
               cnt_d = cnt_q - HOLD_W'(1'b1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pattern for the values the sequencer will hold after this edge.
   stim_pattern_map u_map (
      .mode_i    (mode_d),
      .index_i   (index_d),
      .pattern_o (pat_s)
   );

   // State, counters and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         index_q <= 4'd0;
         cnt_q   <= {HOLD_W{1'b0}};
         hold_q  <= {HOLD_W{1'b0}};
         mode_q  <= 2'b00;
         pat_q   <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         mode_q  <= mode_d;
         pat_q   <= (state_d == RUN) ? pat_s : 4'd0;
         valid_q <= (state_d == RUN);
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
      end
   end

   assign a     = pat_q[0];
   assign b     = pat_q[1];
   assign c     = pat_q[2];
   assign d     = pat_q[3];
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_orgate_stim_gen.sv
// Self-checking bench for orgate_stim_gen: directed scenarios plus randomized
// runs, each cycle compared against an arithmetic model of the sequence.
module tb_orgate_stim_gen;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [1:0] mode;
   logic [7:0] hold;
   logic       a, b, c, d;
   logic       valid, busy, done;

   int n_checks;
   int n_errors;

   orgate_stim_gen #(.HOLD_W(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .abort (abort),
      .mode  (mode),
      .hold  (hold),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .valid (valid),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference pattern straight from the mode rules.
   function automatic logic [3:0] ref_pat(input int m, input int i);
      if (m == 2)      return 4'(1 << i);
      else if (m == 1) return 4'(i ^ (i >> 1));
      else             return 4'(i);
   endfunction

   // One sequence: start, then per-cycle checks. cut_at >= 0 cancels the run
   // at that cycle via abort (kind 0) or rst (kind 1). noise scrambles mode,
   // hold and start while busy, which must not affect the run.
   task automatic run_seq(input int m, input int h, input int cut_at,
                          input int cut_kind, input bit noise);
      int  plen, total, prev;
      bit  gone;
      plen  = (m == 2) ? 4 : 16;
      total = plen * (h + 1);
      mode  = 2'(m);
      hold  = 8'(h);
      abort = 1'b0;
      start = 1'b1;
      tick;
      start = 1'b0;
      prev  = -1;
      gone  = 1'b0;
      for (int k = 0; k < total && !gone; k++) begin
         chk_eq("run_status", {29'd0, valid, busy, done}, 32'b110);
         chk_eq("run_pattern", {28'd0, d, c, b, a}, {28'd0, ref_pat(m, k / (h + 1))});
         if (m == 1 && prev >= 0 && (k % (h + 1)) == 0)
            chk_eq("gray_step", $countones(4'(prev) ^ {d, c, b, a}), 32'd1);
         prev = int'({d, c, b, a});
         if (k == cut_at) begin
            start = 1'b0;
            if (cut_kind == 0) abort = 1'b1;
            else               rst   = 1'b1;
            tick;
            abort = 1'b0;
            rst   = 1'b0;
            chk_eq("cut_status", {29'd0, valid, busy, done}, 32'd0);
            chk_eq("cut_pattern", {28'd0, d, c, b, a}, 32'd0);
            tick;
            chk_eq("cut_idle", {29'd0, valid, busy, done}, 32'd0);
            gone = 1'b1;
         end else begin
            if (noise) begin
               mode  = 2'($urandom);
               hold  = 8'($urandom);
               start = 1'($urandom);
            end
            tick;
         end
      end
      if (!gone) begin
         chk_eq("done_status", {29'd0, valid, busy, done}, 32'b011);
         chk_eq("done_pattern", {28'd0, d, c, b, a}, 32'd0);
         start = 1'b0;
         tick;
         chk_eq("after_done", {29'd0, valid, busy, done}, 32'd0);
      end
   endtask

   initial begin
      int m, h, cut, kind, plen;
      n_checks = 0;
      n_errors = 0;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = 2'b00;
      hold  = 8'd0;
      tick;
      tick;
      chk_eq("reset_status", {29'd0, valid, busy, done}, 32'd0);
      chk_eq("reset_pattern", {28'd0, d, c, b, a}, 32'd0);
      rst = 1'b0;
      tick;
      chk_eq("idle_status", {29'd0, valid, busy, done}, 32'd0);

      run_seq(0, 0, -1, 0, 1'b0);      // binary, one cycle per pattern
      run_seq(0, 2, -1, 0, 1'b0);      // hold counter
      run_seq(1, 0, -1, 0, 1'b0);      // Gray
      run_seq(1, 1, -1, 0, 1'b0);
      run_seq(2, 0, -1, 0, 1'b1);      // walking-one, inputs changed mid-run
      run_seq(3, 0, -1, 0, 1'b0);      // reserved mode behaves as binary
      run_seq(0, 0, 6, 0, 1'b0);       // abort at pattern 0110
      run_seq(0, 1, 9, 1, 1'b0);       // reset mid-run
      run_seq(0, 0, -1, 0, 1'b1);      // start pulses during run ignored

      // start and abort together in IDLE: abort wins
      mode  = 2'b00;
      hold  = 8'd0;
      start = 1'b1;
      abort = 1'b1;
      tick;
      chk_eq("start_abort", {29'd0, valid, busy, done}, 32'd0);
      start = 1'b0;
      abort = 1'b0;
      tick;
      chk_eq("start_abort_idle", {29'd0, valid, busy, done}, 32'd0);

      // maximum hold: pattern 0 for 256 cycles, then 0001
      run_seq(0, 255, 257, 0, 1'b0);

      for (int r = 0; r < 30; r++) begin
         m    = int'($urandom_range(0, 3));
         h    = int'($urandom_range(0, 4));
         plen = (m == 2) ? 4 : 16;
         kind = int'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) cut = int'($urandom_range(0, plen * (h + 1) - 1));
         else                           cut = -1;
         run_seq(m, h, cut, kind, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/orgate_stim_gen.md
# orgate_stim_gen

Synthesizable stimulus sequencer sitting directly upstream of the 4-input OR-gate stage. It drives that stage's `a`, `b`, `c`, `d` inputs with a programmable pattern sequence, holding each pattern for a set number of cycles. A start/done handshake lets a board-level controller or bench exercise the gate exhaustively without free-running toggle logic.

## Interface
Parameters:
- `HOLD_W`, 8, width of the per-pattern hold count.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  start request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a running sequence.
- `mode`  in  2  pattern mode; latched on accepted start.
- `hold`  in  HOLD_W  extra cycles per pattern; latched on accepted start.
- `a`, `b`, `c`, `d`  out  1 each  stimulus bits to the OR-gate stage (`a` = LSB, `d` = MSB).
- `valid`  out  1  high while `a`..`d` carry a sequence pattern.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at normal sequence completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 and `abort`=0 moves to RUN.
  - On that transition: latch `mode` and `hold`, set index=0, and load the hold counter with `hold`.
- **RUN:**
  - Output `{d,c,b,a}` = map(mode, index).
  - The hold counter decrements each cycle.
  - At counter=0:
    - If index is not last: index+1 and reload `hold`.
    - If index is last: go to DONE.
- **DONE:** one cycle, then IDLE.
- **Modes:**
  - 00 binary: index 0..15, pattern = index.
  - 01 Gray: index 0..15, pattern = index ^ (index >> 1).
  - 10 walking-one: index 0..3, pattern = 1 << index.
  - 11 reserved: behaves as 00.
- Last index is 15 for modes 00, 01 and 11, and 3 for mode 10.
- **Outputs by state:**
  - Outside RUN: `a`..`d` = 0 and `valid` = 0.
  - In RUN: `valid` = 1.
- **Boundary conditions:**
  - `start` in RUN or DONE is ignored; it is not queued.
  - `abort` in RUN: go to IDLE next cycle, outputs 0, no `done` pulse.
  - `abort` in IDLE or DONE: no effect, except that `start` and `abort` together in IDLE keeps the FSM in IDLE (abort wins).
  - `rst` at any time, including mid-RUN: next cycle IDLE, index 0, counter 0, all outputs 0.
  - `hold` = 0: one cycle per pattern.
  - `hold` = 2^HOLD_W−1: 2^HOLD_W cycles per pattern, with no wrap of the counter.
  - Index and counter never wrap: the index is at most 4 bits and is compared against last before incrementing.
  - Changing `mode` or `hold` while busy has no effect on the run in progress.

## Timing
- All outputs are registered.
- Reset values: `a`=`b`=`c`=`d`=0, `valid`=0, `busy`=0, `done`=0.
- `start` sampled high at edge N gives `valid`=1 and pattern 0 from cycle N+1.
- Each pattern is held for exactly `hold`+1 cycles.
- Run length is P·(`hold`+1) cycles, where P = 16 (binary/Gray) or 4 (walking-one).
- `done` is high in cycle N+1+P·(`hold`+1), and `busy` is high in that same cycle.
- IDLE follows one cycle later, so the earliest new accepted start is sampled in the cycle after `done`.
- Pattern changes are aligned to clock edges; there is no glitch between patterns.

## Structure
- Package `orgate_stim_pkg` holds:
  - state enum (IDLE, RUN, DONE)
  - mode constants (MODE_BIN, MODE_GRAY, MODE_WALK)
  - last-index constants (LAST_16 = 15, LAST_WALK = 3)
- One combinational sub-module, `stim_pattern_map`: (mode[1:0], index[3:0]) → pattern[3:0].
- The FSM, hold counter and output registers stay in the top module.

## Test plan
1. **Reset defaults:** assert `rst` 2 cycles → all outputs 0. Then `start` with `mode`=00, `hold`=0 at edge N → `{d,c,b,a}` = 0000, 0001, …, 1111 on cycles N+1..N+16; `done` at N+17; `busy` low at N+18.
2. **Hold counter:** `mode`=00, `hold`=2 → each pattern held 3 cycles; pattern 0101 in cycles N+16..N+18; `done` at N+49.
3. **Gray mode:** `mode`=01, `hold`=0 → index 3 gives 0010 and index 15 gives 1000; consecutive patterns differ in exactly one bit.
4. **Walking-one:** `mode`=10, `hold`=0 → 0001, 0010, 0100, 1000 on N+1..N+4; `done` at N+5. Change `mode` to 00 mid-run → sequence unchanged.
5. **Abort, reset and ignored start:**
   - `abort` at pattern 0110 → IDLE next cycle, outputs 0, no `done`.
   - `rst` mid-run → same result.
   - `start`+`abort` together in IDLE → stays IDLE.
   - `start` pulsed during RUN → ignored; run length still 16.
6. **Maximum hold:** `hold`=255 → pattern 0 held exactly 256 cycles before 0001 appears.
